// File: rtl/uart_apb_pkg.sv
// Shared types and byte constants for the serial-to-APB debug bridge.
package uart_apb_pkg;

  // Frame-level states of the bridge.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_APB_SETUP,
    S_APB_ACCESS,
    S_TX_STATUS,
    S_TX_DATA
  } state_e;

  // Bus-phase states of the APB port sequencer.
  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_ACCESS
  } port_state_e;

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SLVERR  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADCMD  = 8'hEE;

endpackage

// File: rtl/apb_master_port.sv
// APB SETUP/ACCESS sequencer with access-phase timeout.
// start_i launches one transfer; done_o pulses in the final access cycle,
// qualified by err_o (PSLVERR at PREADY) or timeout_o (no PREADY in time).
module apb_master_port
  import uart_apb_pkg::*;
#(
  parameter int APB_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic pready_i,
  input  logic pslverr_i,
  output logic psel_o,
  output logic penable_o,
  output logic done_o,
  output logic err_o,
  output logic timeout_o
);

  localparam int CW = $clog2(APB_TIMEOUT + 1);

  port_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bus strobes decode straight from the registered state so they are glitch-free.
  assign psel_o    = (state_q != P_IDLE);
  assign penable_o = (state_q == P_ACCESS);

  // Next-state logic; PREADY is examined before the timeout so it wins a tie.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_o    = 1'b0;
    err_o     = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (start_i) begin
          state_d = P_SETUP;
          cnt_d   = '0;
        end
      end
      P_SETUP: begin
        state_d = P_ACCESS;
      end
      P_ACCESS: begin
        if (pready_i) begin
          done_o  = 1'b1;
          err_o   = pslverr_i;
          state_d = P_IDLE;
        end else if (cnt_q == CW'(APB_TIMEOUT - 1)) begin
          done_o    = 1'b1;
          timeout_o = 1'b1;
          state_d   = P_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= P_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_apb_master.sv
// Serial debug bridge: decodes framed read/write commands from a byte
// stream, runs one APB transfer per frame and returns status (+ read data).
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RX_TIMEOUT  = 100000,
  parameter int APB_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_done_i,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int TW = $clog2(RX_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic          pwrite_q, pwrite_d;
  logic          has_data_q, has_data_d;
  logic          gap_q, gap_d;
  logic          overrun_q, overrun_d;
  logic [TW-1:0] timer_q, timer_d;

  logic apb_start, apb_done, apb_err, apb_timeout;
  logic tx_fire;

  apb_master_port #(
    .APB_TIMEOUT(APB_TIMEOUT)
  ) u_port (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (apb_start),
    .pready_i (PREADY),
    .pslverr_i(PSLVERR),
    .psel_o   (PSEL),
    .penable_o(PENABLE),
    .done_o   (apb_done),
    .err_o    (apb_err),
    .timeout_o(apb_timeout)
  );

  assign PADDR     = addr_q[ADDR_WIDTH-1:0];
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwrite_q ? data_q : 32'h0;
  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = overrun_q;
  // gap_q forces the one idle cycle between consecutive tx bytes.
  assign tx_valid_o = ((state_q == S_TX_STATUS) || (state_q == S_TX_DATA)) && !gap_q;
  assign tx_fire    = tx_valid_o && tx_done_i;

  // Byte presented to the transmitter.
  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == S_TX_STATUS) tx_data_o = status_q;
    else if (state_q == S_TX_DATA) tx_data_o = rdata_q[{cnt_q, 3'b000} +: 8];
  end

  // Frame decode, APB hand-off and response sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    pwrite_d   = pwrite_q;
    has_data_d = has_data_q;
    gap_d      = 1'b0;
    overrun_d  = 1'b0;
    timer_d    = '0;
    apb_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_valid_i) begin
          if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
            pwrite_d   = (rx_data_i == CMD_WRITE);
            has_data_d = (rx_data_i == CMD_READ);
            addr_d     = '0;
            data_d     = '0;
            state_d    = S_RX_ADDR;
          end else begin
            status_d   = ST_BADCMD;
            has_data_d = 1'b0;
            state_d    = S_TX_STATUS;
          end
        end
      end
      S_RX_ADDR, S_RX_DATA: begin
        if (rx_valid_i) begin
          if (state_q == S_RX_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          else                      data_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == S_RX_ADDR && pwrite_q) begin
              state_d = S_RX_DATA;
            end else begin
              state_d   = S_APB_SETUP;
              apb_start = 1'b1;
            end
          end
        end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_APB_SETUP: begin
        overrun_d = rx_valid_i;
        state_d   = S_APB_ACCESS;
      end
      S_APB_ACCESS: begin
        overrun_d = rx_valid_i;
        if (apb_done) begin
          if (apb_timeout) begin
            status_d = ST_TIMEOUT;
            rdata_d  = '0;
          end else begin
            status_d = apb_err ? ST_SLVERR : ST_OK;
            rdata_d  = (!pwrite_q && !apb_err) ? PRDATA : 32'h0;
          end
          state_d = S_TX_STATUS;
        end
      end
      S_TX_STATUS: begin
        overrun_d = rx_valid_i;
        if (tx_fire) begin
          if (has_data_q) begin
            state_d = S_TX_DATA;
            cnt_d   = '0;
            gap_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TX_DATA: begin
        overrun_d = rx_valid_i;
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_IDLE;
          else               gap_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      pwrite_q   <= 1'b0;
      has_data_q <= 1'b0;
      gap_q      <= 1'b0;
      overrun_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      pwrite_q   <= pwrite_d;
      has_data_q <= has_data_d;
      gap_q      <= gap_d;
      overrun_q  <= overrun_d;
      timer_q    <= timer_d;
    end
  end

endmodule
